// File: rtl/rtc_display_scanner.sv
// ---------------------------------------------------------------------------
// RtcDisplayScanner: time-multiplexed scanner for the Nexys A7 seven-segment
// display. It walks digits 0..5, holds every anode off for a short blank
// interval at the start of each digit slot to suppress ghosting, and takes a
// snapshot of all six segment patterns at frame start so a frame never
// mixes old and new digits.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous reset, active-low
//   i_seg1..i_seg6 active-low segment patterns for digits 0..5 (bit7 = DP),
//                  i_seg1 is the rightmost digit
//   i_blank        force the display dark; scanning keeps running
//   o_an           active-low anode enables, at most one bit low
//   o_seg          active-low cathode pattern (bit7 = DP)
//   o_frame_tick   one-cycle pulse following each frame snapshot
// ---------------------------------------------------------------------------
module rtc_display_scanner #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_seg1,
    input  logic [7:0] i_seg2,
    input  logic [7:0] i_seg3,
    input  logic [7:0] i_seg4,
    input  logic [7:0] i_seg5,
    input  logic [7:0] i_seg6,
    input  logic       i_blank,
    output logic [7:0] o_an,
    output logic [7:0] o_seg,
    output logic       o_frame_tick
);

    localparam int CNT_W = $clog2(DIGIT_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_TICKS);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shadow [0:5];

    logic       w_cntLast;
    logic       w_snapshot;
    logic       w_blankPhase;
    logic       w_dark;
    logic [7:0] w_anOn;
    logic [7:0] w_digitSeg;

    assign w_cntLast  = (r_cnt == CNT_LAST);
    assign w_snapshot = (r_idx == 3'd0) && (r_cnt == '0);

    // With no blank interval the comparison would be constant-false, so it
    // is only built when a blank interval exists.
    generate
        if (BLANK_TICKS == 0) begin : g_noBlank
            assign w_blankPhase = 1'b0;
        end else begin : g_blank
            assign w_blankPhase = (r_cnt < BLANK_CNT);
        end
    endgenerate

    assign w_dark = w_blankPhase || i_blank;

    // Anode code per digit; the two leftmost anodes stay off permanently.
    always_comb begin
        w_anOn = 8'hFF;
        case (r_idx)
            3'd0:    w_anOn = 8'hFE;
            3'd1:    w_anOn = 8'hFD;
            3'd2:    w_anOn = 8'hFB;
            3'd3:    w_anOn = 8'hF7;
            3'd4:    w_anOn = 8'hEF;
            3'd5:    w_anOn = 8'hDF;
            default: w_anOn = 8'hFF;
        endcase
    end

    // Digit 0 on the snapshot edge shows the value being loaded, so a new
    // frame is visible from its very first ON cycle (matters when there is
    // no blank interval).
    always_comb begin
        w_digitSeg = 8'hFF;
        case (r_idx)
            3'd0:    w_digitSeg = w_snapshot ? i_seg1 : r_shadow[0];
            3'd1:    w_digitSeg = r_shadow[1];
            3'd2:    w_digitSeg = r_shadow[2];
            3'd3:    w_digitSeg = r_shadow[3];
            3'd4:    w_digitSeg = r_shadow[4];
            3'd5:    w_digitSeg = r_shadow[5];
            default: w_digitSeg = 8'hFF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            for (int k = 0; k < 6; k++) begin
                r_shadow[k] <= 8'hFF;
            end
            o_an         <= 8'hFF;
            o_seg        <= 8'hFF;
            o_frame_tick <= 1'b0;
        end else begin
            if (w_cntLast) begin
                r_cnt <= '0;
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_snapshot) begin
                r_shadow[0] <= i_seg1;
                r_shadow[1] <= i_seg2;
                r_shadow[2] <= i_seg3;
                r_shadow[3] <= i_seg4;
                r_shadow[4] <= i_seg5;
                r_shadow[5] <= i_seg6;
            end
            o_frame_tick <= w_snapshot;

            if (w_dark) begin
                o_an  <= 8'hFF;
                o_seg <= 8'hFF;
            end else begin
                o_an  <= w_anOn;
                o_seg <= w_digitSeg;
            end
        end
    end

endmodule

// File: tb/tb_rtc_display_scanner.sv
// ---------------------------------------------------------------------------
// Testbench for rtc_display_scanner. Two instances share all inputs: one with
// DIGIT_TICKS=4/BLANK_TICKS=1 and one with DIGIT_TICKS=4/BLANK_TICKS=0.
// Expected outputs come from a per-edge reference of the scan sequence plus a
// few hand-computed constants.
// ---------------------------------------------------------------------------
module tb_rtc_display_scanner;

    logic       clk;
    logic       rstN;
    logic [7:0] seg [0:5];
    logic       blank;

    logic [7:0] an1, segOut1, an0, segOut0;
    logic       tick1, tick0;

    int checks   = 0;
    int failures = 0;

    // Reference model state: n = edges since reset release (pre-edge).
    int         n;
    logic [7:0] mShadow [0:5];
    logic [7:0] anTable [0:5];

    int badAn1 = 0;
    int badAn0 = 0;
    int bad76  = 0;

    rtc_display_scanner #(.DIGIT_TICKS(4), .BLANK_TICKS(1)) dutBlank (
        .i_clk(clk), .i_rst_n(rstN),
        .i_seg1(seg[0]), .i_seg2(seg[1]), .i_seg3(seg[2]),
        .i_seg4(seg[3]), .i_seg5(seg[4]), .i_seg6(seg[5]),
        .i_blank(blank),
        .o_an(an1), .o_seg(segOut1), .o_frame_tick(tick1)
    );

    rtc_display_scanner #(.DIGIT_TICKS(4), .BLANK_TICKS(0)) dutNoBlank (
        .i_clk(clk), .i_rst_n(rstN),
        .i_seg1(seg[0]), .i_seg2(seg[1]), .i_seg3(seg[2]),
        .i_seg4(seg[3]), .i_seg5(seg[4]), .i_seg6(seg[5]),
        .i_blank(blank),
        .o_an(an0), .o_seg(segOut0), .o_frame_tick(tick0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit anLegal(input logic [7:0] a);
        return (a == 8'hFF) || (a[7:6] == 2'b11 && $countones(~a) == 1);
    endfunction

    // Anode legality monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!anLegal(an1)) badAn1++;
        if (!anLegal(an0)) badAn0++;
        if (an1[7:6] != 2'b11 || an0[7:6] != 2'b11) bad76++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s edge=%0d actual=%0h expected=%0h",
                     tag, n, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s1, input logic [7:0] s2,
                                 input logic [7:0] s3, input logic [7:0] s4,
                                 input logic [7:0] s5, input logic [7:0] s6);
        seg[0] = s1; seg[1] = s2; seg[2] = s3;
        seg[3] = s4; seg[4] = s5; seg[5] = s6;
    endtask

    // Advance the given number of edges, checking both instances after each.
    task automatic runEdges(input int count);
        logic [7:0] expAn1, expSeg1, expAn0, expSeg0;
        logic       expTick;
        int         cnt, idx;
        for (int e = 0; e < count; e++) begin
            if (!rstN) begin
                expAn1 = 8'hFF; expSeg1 = 8'hFF;
                expAn0 = 8'hFF; expSeg0 = 8'hFF;
                expTick = 1'b0;
                for (int k = 0; k < 6; k++) mShadow[k] = 8'hFF;
                n = 0;
            end else begin
                cnt = n % 4;
                idx = (n / 4) % 6;
                expTick = (n % 24 == 0);
                if (expTick) begin
                    for (int k = 0; k < 6; k++) mShadow[k] = seg[k];
                end
                if (blank || cnt < 1) begin
                    expAn1 = 8'hFF; expSeg1 = 8'hFF;
                end else begin
                    expAn1 = anTable[idx]; expSeg1 = mShadow[idx];
                end
                if (blank) begin
                    expAn0 = 8'hFF; expSeg0 = 8'hFF;
                end else begin
                    expAn0 = anTable[idx]; expSeg0 = mShadow[idx];
                end
                n++;
            end
            @(posedge clk);
            #1;
            checkOutput("an_b1",   an1,     expAn1);
            checkOutput("seg_b1",  segOut1, expSeg1);
            checkOutput("tick_b1", tick1,   expTick);
            checkOutput("an_b0",   an0,     expAn0);
            checkOutput("seg_b0",  segOut0, expSeg0);
            checkOutput("tick_b0", tick0,   expTick);
        end
    endtask

    initial begin
        int ticks1, ticks0;
        anTable[0] = 8'hFE; anTable[1] = 8'hFD; anTable[2] = 8'hFB;
        anTable[3] = 8'hF7; anTable[4] = 8'hEF; anTable[5] = 8'hDF;
        n = 0;
        rstN  = 1'b0;
        blank = 1'b0;
        applyStimulus(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);

        // Reset state.
        runEdges(2);

        // Release; first edge takes the snapshot and stays blank.
        rstN = 1'b1;
        runEdges(1);
        checkOutput("first_tick", tick1, 1);
        checkOutput("first_an",   an1,   8'hFF);
        checkOutput("first_an0",  an0,   8'hFE);
        checkOutput("first_seg0", segOut0, 8'hC0);
        runEdges(1);
        checkOutput("edge2_an",  an1,     8'hFE);
        checkOutput("edge2_seg", segOut1, 8'hC0);
        runEdges(4);
        checkOutput("edge6_an",  an1,     8'hFD);
        checkOutput("edge6_seg", segOut1, 8'hF9);
        runEdges(3);

        // Force dark over edges 10..14, then resume mid-slot.
        blank = 1'b1;
        runEdges(5);
        blank = 1'b0;
        runEdges(1);
        checkOutput("resume_an",  an1,     8'hF7);
        checkOutput("resume_seg", segOut1, 8'hB0);

        // New digit-0 pattern while on digit 3: must wait for next frame.
        applyStimulus(8'h82, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
        runEdges(9);
        checkOutput("pre_snap_tick", tick1, 0);
        runEdges(1);
        checkOutput("snap25_tick", tick1, 1);
        runEdges(1);
        checkOutput("frame2_seg", segOut1, 8'h82);
        runEdges(22);

        // Reset mid-scan at idx=4, cnt=2, then restart with fresh inputs.
        runEdges(18);
        rstN = 1'b0;
        runEdges(1);
        checkOutput("midrst_an",  an1,     8'hFF);
        checkOutput("midrst_seg", segOut1, 8'hFF);
        rstN = 1'b1;
        applyStimulus(8'h82, 8'h88, 8'hA4, 8'hB0, 8'h99, 8'h92);
        runEdges(30);

        // Long run: frame ticks and anode rules over 1000 frames.
        ticks1 = 0;
        ticks0 = 0;
        for (int e = 0; e < 24000; e++) begin
            @(posedge clk);
            #1;
            if (tick1) ticks1++;
            if (tick0) ticks0++;
        end
        checkOutput("ticks_b1",   ticks1, 1000);
        checkOutput("ticks_b0",   ticks0, 1000);
        checkOutput("an76",       bad76,  0);
        checkOutput("onehot_b1",  badAn1, 0);
        checkOutput("onehot_b0",  badAn0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_display_scanner.md
Name: rtc_display_scanner

Overview:
Time-multiplexed scanner that drives the six 8-bit segment patterns produced by the BCD-to-7-segment driver onto the Nexys A7 shared cathode bus and 8 active-low anodes. It cycles digits 0..5, applies an anti-ghosting blank interval at the start of each digit slot, and latches a full frame of inputs at frame start so a display never tears mid-scan. It sits between the display driver outputs and the board pins.

Parameters:
DIGIT_TICKS, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2
BLANK_TICKS, 1000, cycles at slot start with all anodes off; 0 <= BLANK_TICKS < DIGIT_TICKS

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  synchronous reset, active-low
i_seg1  input  8  segment pattern for digit 0 (rightmost); active-low, bit7 = DP
i_seg2  input  8  pattern for digit 1
i_seg3  input  8  pattern for digit 2
i_seg4  input  8  pattern for digit 3
i_seg5  input  8  pattern for digit 4
i_seg6  input  8  pattern for digit 5
i_blank  input  1  force display dark; scanning continues
o_an  output  8  anode enables, active-low, one-hot-low or all high
o_seg  output  8  cathode pattern, active-low, bit7 = DP
o_frame_tick  output  1  one-cycle pulse after each frame snapshot

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-low (i_rst_n).
- Internal state: cnt (0..DIGIT_TICKS-1), idx (0..5), shadow[0..5] (8 bits each).
- Reset: cnt=0, idx=0, shadow[*]=8'hFF, o_an=8'hFF, o_seg=8'hFF, o_frame_tick=0. Reset asserted mid-scan takes effect on the next edge and fully restarts the scan from frame start.
- Counting, per edge: if cnt==DIGIT_TICKS-1, then cnt->0 and idx->(idx==5 ? 0 : idx+1). Otherwise cnt->cnt+1.
- Phase is a function of the pre-edge cnt: BLANK when cnt < BLANK_TICKS, ON otherwise. BLANK_TICKS=0 means no BLANK phase.
- Snapshot: on every edge where the pre-edge state is idx==0 and cnt==0, shadow[k] <= i_seg(k+1) for all k. This edge is the first edge after reset release and then once per 6*DIGIT_TICKS cycles. Inputs are ignored at all other times.
- o_frame_tick: registered. It is 1 for exactly the one cycle following each snapshot edge and 0 otherwise.
- Outputs are registered and derived from the pre-edge state (one-cycle latency):
  - BLANK, or i_blank==1: o_an=8'hFF and o_seg=8'hFF.
  - ON: o_an = ~(8'b1 << idx) and o_seg = shadow[idx].
  - For digit 0, ON uses the just-loaded shadow value: the load and the output update share the priority rule that the new frame is visible from that frame's first ON cycle.
- o_an[7:6] are always 1 (the two leftmost digits are unused).
- i_blank is sampled every cycle with no latching. Deasserting it mid-slot restores the display on the next edge.
- Wrap: after idx 5 the next slot is idx 0 with a new snapshot. No gap cycles between slots.
- Simultaneous events: when a snapshot and i_blank coincide, the snapshot still occurs and o_frame_tick still pulses.
- Invariant: never more than one o_an bit low.

Test Plan:
(Bench params: DIGIT_TICKS=4, BLANK_TICKS=1.)
- Reset then release with i_seg1..6 = C0,F9,A4,B0,99,92 -> o_frame_tick=1 in cycle 1 only. o_an=FF for edge 1. Edges 2-4: o_an=FE, o_seg=C0. Edge 5: FF/FF. Edges 6-8: o_an=FD, o_seg=F9. Sequence continues through o_an=DF, o_seg=92, then repeats.
- Change i_seg1 to 82 while idx=3 -> digit 0 keeps showing C0 until the next snapshot edge (cycle 25), then shows 82. o_frame_tick pulses every 24 cycles.
- Hold i_blank=1 for cycles 10-14 -> o_an=FF and o_seg=FF on the following edges, with cnt/idx unaffected. Display resumes at the correct digit and phase on the next edge.
- Assert i_rst_n=0 for one cycle at idx=4, cnt=2 -> next edge gives o_an=FF, o_seg=FF, shadow=FF. Scan restarts at digit 0 with a new snapshot.
- Rebuild with BLANK_TICKS=0 -> each digit is on for all 4 cycles with no FF gap. An assertion checks o_an one-hot-low or FF every cycle.
- Long run of 1000 frames -> o_an[7:6] is always 1 and o_frame_tick count equals the frame count.
